// File: rtl/draw_pkg.sv
//------------------------------------------------------------------------------
// Module   : draw_pkg
// Purpose  : Shared constants and types for the draw engine: screen geometry,
//            fixed region placements, colour codes, the command encoding and
//            the FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package draw_pkg;

  // Clip limits, one bit wider than the coordinates so that origin + offset
  // can be compared without wrapping.
  localparam logic [8:0] SCREEN_W   = 9'd160;
  localparam logic [7:0] SCREEN_H   = 8'd120;

  // Full-screen region size in coordinate widths.
  localparam logic [7:0] FULL_W     = SCREEN_W[7:0];
  localparam logic [6:0] FULL_H     = SCREEN_H[6:0];

  // Fixed regions.
  localparam logic [7:0] SCORE_X    = 8'd8;
  localparam logic [6:0] SCORE_Y    = 7'd4;
  localparam logic [7:0] SCORE_W    = 8'd64;
  localparam logic [6:0] SCORE_H    = 7'd4;
  localparam logic [7:0] OSU_SIZE   = 8'd8;
  localparam logic [6:0] LINE_Y     = 7'd100;

  // Colours.
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BG     = 3'b001;
  localparam logic [2:0] COL_SCORE  = 3'b010;
  localparam logic [2:0] COL_OSU    = 3'b100;
  localparam logic [2:0] COL_LINE   = 3'b111;

  typedef enum logic [2:0] {
    CMD_BLACK = 3'd0,
    CMD_BG    = 3'd1,
    CMD_SCORE = 3'd2,
    CMD_OSU   = 3'd3,
    CMD_LINE  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // ld vector is {line, osu, score, BG, black}; lowest set bit wins.
  function automatic cmd_e pick_cmd(input logic [4:0] ld);
    cmd_e c;
    c = CMD_BLACK;
    if (ld[4]) c = CMD_LINE;
    if (ld[3]) c = CMD_OSU;
    if (ld[2]) c = CMD_SCORE;
    if (ld[1]) c = CMD_BG;
    if (ld[0]) c = CMD_BLACK;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rect_sweeper.sv
//------------------------------------------------------------------------------
// Module   : rect_sweeper
// Purpose  : Raster-order offset counter for a w x h rectangle. cx advances
//            fastest; 'last' flags the final offset (w-1, h-1).
// Ports    : clk, resetn        clock, async active-low reset
//            load               clear cx/cy to 0 (wins over step)
//            step               advance one pixel
//            w [7:0], h [6:0]   rectangle size (both >= 1)
//            cx [7:0], cy [6:0] current offset
//            last               current offset is the final pixel
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rect_sweeper (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       last
);

  logic w_row_end;
  logic w_col_end;

  assign w_row_end = (cx == w - 8'd1);
  assign w_col_end = (cy == h - 7'd1);
  assign last      = w_row_end && w_col_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (w_row_end) begin
        cx <= '0;
        cy <= w_col_end ? 7'd0 : cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/draw_engine.sv
//------------------------------------------------------------------------------
// Module   : draw_engine
// Purpose  : Accepts a draw command from the game controller, rasterises the
//            matching rectangle one pixel per clock into the 160x120 VGA
//            adapter and returns the command's completion flag.
// Ports    : clk, resetn                     clock, async active-low reset
//            ld_black/ld_BG/ld_score/ld_osu/ld_line   draw commands
//            osu_x [7:0], osu_y [6:0]        sprite origin (latched at accept)
//            score [3:0]                     score value (latched at accept)
//            x [7:0], y [6:0], colour [2:0], plot   pixel write to VGA
//            cleared/draw/drewScore/drewOsu/drewLine completion flags
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module draw_engine
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_black,
  input  logic       ld_BG,
  input  logic       ld_score,
  input  logic       ld_osu,
  input  logic       ld_line,
  input  logic [7:0] osu_x,
  input  logic [6:0] osu_y,
  input  logic [3:0] score,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       cleared,
  output logic       draw,
  output logic       drewScore,
  output logic       drewOsu,
  output logic       drewLine
);

  logic [4:0] w_ld;
  cmd_e       w_cmd_in;
  state_e     r_state, w_state_nxt;
  cmd_e       r_cmd;
  logic [7:0] r_x0, r_w;
  logic [6:0] r_y0, r_h;
  logic [3:0] r_score;
  logic       w_held, w_accept, w_emit;
  logic [7:0] w_cx;
  logic [6:0] w_cy;
  logic       w_last;
  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic       w_inside;
  logic [2:0] w_col;
  logic [4:0] r_flag;

  assign w_ld     = {ld_line, ld_osu, ld_score, ld_BG, ld_black};
  assign w_cmd_in = pick_cmd(w_ld);

  // The accepted command's own request line keeps the transaction alive.
  always_comb begin
    w_held = 1'b0;
    case (r_cmd)
      CMD_BLACK: w_held = ld_black;
      CMD_BG:    w_held = ld_BG;
      CMD_SCORE: w_held = ld_score;
      CMD_OSU:   w_held = ld_osu;
      CMD_LINE:  w_held = ld_line;
      default:   w_held = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // The counter is cleared on accept, so LOAD already presents offset (0,0)
  // and emits the first pixel into the output register; the pixel therefore
  // appears on the outputs two cycles after the command is seen.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_ld) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD, ST_SWEEP: begin
        if (!w_held) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_emit      = 1'b1;
          w_state_nxt = w_last ? ST_ACK : ST_SWEEP;
        end
      end
      ST_ACK: begin
        if (!w_held) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Region and parameter latch, loaded only when a command is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd   <= CMD_BLACK;
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_score <= '0;
    end else if (w_accept) begin
      r_cmd   <= w_cmd_in;
      r_score <= score;
      case (w_cmd_in)
        CMD_SCORE: begin
          r_x0 <= SCORE_X;  r_y0 <= SCORE_Y;  r_w <= SCORE_W;  r_h <= SCORE_H;
        end
        CMD_OSU: begin
          r_x0 <= osu_x;    r_y0 <= osu_y;    r_w <= OSU_SIZE; r_h <= OSU_SIZE[6:0];
        end
        CMD_LINE: begin
          r_x0 <= 8'd0;     r_y0 <= LINE_Y;   r_w <= FULL_W;   r_h <= 7'd1;
        end
        default: begin
          r_x0 <= 8'd0;     r_y0 <= 7'd0;     r_w <= FULL_W;   r_h <= FULL_H;
        end
      endcase
    end
  end

  rect_sweeper u_sweeper (
    .clk    (clk),
    .resetn (resetn),
    .load   (w_accept),
    .step   (w_emit),
    .w      (r_w),
    .h      (r_h),
    .cx     (w_cx),
    .cy     (w_cy),
    .last   (w_last)
  );

  // Widened sums so an off-screen sprite cannot wrap back onto the screen.
  assign w_sx     = {1'b0, r_x0} + {1'b0, w_cx};
  assign w_sy     = {1'b0, r_y0} + {1'b0, w_cy};
  assign w_inside = (w_sx < SCREEN_W) && (w_sy < SCREEN_H);

  always_comb begin
    w_col = COL_BLACK;
    case (r_cmd)
      CMD_BLACK: w_col = COL_BLACK;
      CMD_BG:    w_col = COL_BG;
      CMD_SCORE: w_col = (w_cx < {2'b00, r_score, 2'b00}) ? COL_SCORE : COL_BLACK;
      CMD_OSU:   w_col = COL_OSU;
      CMD_LINE:  w_col = COL_LINE;
      default:   w_col = COL_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= w_emit && w_inside;
      if (w_emit) begin
        x      <= w_sx[7:0];
        y      <= w_sy[6:0];
        colour <= w_col;
      end
    end
  end

  // Flag bit order matches the ld vector: {line, osu, score, BG, black}.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flag <= '0;
    end else if (r_state == ST_ACK && w_held) begin
      r_flag <= 5'd1 << r_cmd;
    end else begin
      r_flag <= '0;
    end
  end

  assign {drewLine, drewOsu, drewScore, draw, cleared} = r_flag;

endmodule

`default_nettype wire

// File: tb/tb_draw_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_draw_engine
// Purpose  : Self-checking bench for draw_engine. A reference model expands
//            each command into its list of visible pixels; a monitor pops and
//            compares every plotted pixel and every flag cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_draw_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_black = 1'b0, ld_BG = 1'b0, ld_score = 1'b0, ld_osu = 1'b0, ld_line = 1'b0;
  logic [7:0] osu_x = '0;
  logic [6:0] osu_y = '0;
  logic [3:0] score = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, cleared, draw, drewScore, drewOsu, drewLine;
  logic [4:0] flags;

  assign flags = {drewLine, drewOsu, drewScore, draw, cleared};

  draw_engine dut (
    .clk       (clk),
    .resetn    (resetn),
    .ld_black  (ld_black),
    .ld_BG     (ld_BG),
    .ld_score  (ld_score),
    .ld_osu    (ld_osu),
    .ld_line   (ld_line),
    .osu_x     (osu_x),
    .osu_y     (osu_y),
    .score     (score),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .cleared   (cleared),
    .draw      (draw),
    .drewScore (drewScore),
    .drewOsu   (drewOsu),
    .drewLine  (drewLine)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int px;
    int py;
    int pc;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       mon_e;
  int         n_tests = 0;
  int         n_fail = 0;
  int         plot_cnt = 0;
  int         flag_cycles = 0;
  logic [4:0] exp_flag = '0;

  task automatic check(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Reference: rectangle geometry per command, visible pixels only.
  task automatic push_model(input int cmd, input int ox, input int oy, input int sc,
                            output int npix);
    int x0, y0, w, h, c;
    x0 = 0; y0 = 0; w = 160; h = 120; c = 0;
    case (cmd)
      0: c = 0;
      1: c = 1;
      2: begin x0 = 8;  y0 = 4;   w = 64;  h = 4; c = 2; end
      3: begin x0 = ox; y0 = oy;  w = 8;   h = 8; c = 4; end
      default: begin y0 = 100; h = 1; c = 7; end
    endcase
    npix = w * h;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        if (x0 + xx < 160 && y0 + yy < 120) begin
          pix_t p;
          p.px = x0 + xx;
          p.py = y0 + yy;
          p.pc = (cmd == 2) ? ((xx < sc * 4) ? 2 : 0) : c;
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic drive_ld(input logic [4:0] m);
    {ld_line, ld_osu, ld_score, ld_BG, ld_black} = m;
  endtask

  // Monitor: one sample per cycle, 1 time unit after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (plot) begin
        plot_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_plot", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pix_x", int'(x), mon_e.px);
          check("pix_y", int'(y), mon_e.py);
          check("pix_colour", int'(colour), mon_e.pc);
        end
      end
      if (flags != 5'd0) begin
        flag_cycles++;
        check("flag_value", int'(flags), int'(exp_flag));
      end
    end
  end

  // Full command: issue, wait for flag with a bound, drop, verify cleanup.
  task automatic run_cmd(input logic [4:0] mask, input int ox, input int oy,
                         input int sc, input string name);
    int  cmd, npix, k0, lat;
    bit  found;
    cmd = 0;
    for (int b = 4; b >= 0; b--) if (mask[b]) cmd = b;
    push_model(cmd, ox, oy, sc, npix);
    exp_flag    = 5'd1 << cmd;
    flag_cycles = 0;
    @(negedge clk);
    osu_x = 8'(ox);
    osu_y = 7'(oy);
    score = 4'(sc);
    drive_ld(mask);
    k0    = cyc;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < npix + 40; i++) begin
      @(negedge clk);
      // Parameters must have been latched at accept.
      if (i == 2) begin
        osu_x = 8'($urandom);
        osu_y = 7'($urandom);
        score = 4'($urandom);
      end
      if (flags != 5'd0) begin
        found = 1'b1;
        lat   = cyc - k0;
        break;
      end
    end
    if (!found) check({name, "_flag_timeout"}, 0, 1);
    else        check({name, "_flag_latency"}, lat, npix + 2);
    drive_ld(5'd0);
    repeat (3) @(negedge clk);
    check({name, "_pixels_left"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, "_flag_cycles"}, flag_cycles, 1);
    exp_flag = '0;
  endtask

  initial begin
    int base, npix;
    logic [4:0] mask;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_flags", int'(flags), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset in the middle of a background sweep.
    push_model(1, 0, 0, 0, npix);
    exp_flag = 5'b00010;
    base     = plot_cnt;
    @(negedge clk);
    drive_ld(5'b00010);
    for (int i = 0; i < 400 && plot_cnt - base < 300; i++) @(negedge clk);
    check("rstmid_progress", plot_cnt - base, 300);
    resetn = 1'b0;
    #1;
    check("rstmid_plot", int'(plot), 0);
    check("rstmid_flags", int'(flags), 0);
    check("rstmid_x", int'(x), 0);
    check("rstmid_y", int'(y), 0);
    drive_ld(5'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_idle_plot", int'(plot), 0);
    check("rstmid_no_more", plot_cnt - base, 300);
    exp_q.delete();
    exp_flag = '0;

    // Directed commands.
    run_cmd(5'b00010, 0, 0, 0, "bg");
    run_cmd(5'b01000, 156, 10, 0, "osu_clip");
    run_cmd(5'b00100, 0, 0, 3, "score3");
    run_cmd(5'b00100, 0, 0, 15, "score15");
    run_cmd(5'b10001, 0, 0, 0, "black_over_line");

    // Line aborted after 50 pixels.
    push_model(4, 0, 0, 0, npix);
    exp_flag    = '0;
    flag_cycles = 0;
    base        = plot_cnt;
    @(negedge clk);
    drive_ld(5'b10000);
    for (int i = 0; i < 300 && plot_cnt - base < 50; i++) @(negedge clk);
    check("abort_progress", plot_cnt - base, 50);
    drive_ld(5'd0);
    @(negedge clk);
    check("abort_plot_next", int'(plot), 0);
    repeat (5) @(negedge clk);
    check("abort_plots", plot_cnt - base, 50);
    check("abort_left", exp_q.size(), 110);
    check("abort_no_flag", flag_cycles, 0);
    exp_q.delete();

    // Randomised small-region commands, random priority combinations.
    for (int t = 0; t < 12; t++) begin
      mask = 5'($urandom_range(1, 7)) << 2;
      run_cmd(mask, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 15)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
